// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/decode handshake bundle for the instruction queue
// Purpose: groups the enqueue, dequeue and status signals of inst_queue.
// Ports (slave view, i.e. the queue):
//   in : Flush, InVld[1:0], InInstr0/1, InPC0/1, OutTake[1:0]
//   out: InReady, OutVld[1:0], OutInstr0/1, OutPC0/1, OutImmSrc0/1,
//        OutImmUse0/1, Count[log2(DEPTH):0]
interface inst_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          Flush;
  logic [1:0]    InVld;
  logic [31:0]   InInstr0;
  logic [31:0]   InInstr1;
  logic [31:0]   InPC0;
  logic [31:0]   InPC1;
  logic          InReady;
  logic [1:0]    OutVld;
  logic [31:0]   OutInstr0;
  logic [31:0]   OutInstr1;
  logic [31:0]   OutPC0;
  logic [31:0]   OutPC1;
  logic [1:0]    OutImmSrc0;
  logic [1:0]    OutImmSrc1;
  logic          OutImmUse0;
  logic          OutImmUse1;
  logic [1:0]    OutTake;
  logic [CW-1:0] Count;

  modport master (
    output Flush, InVld, InInstr0, InInstr1, InPC0, InPC1, OutTake,
    input  InReady, OutVld, OutInstr0, OutInstr1, OutPC0, OutPC1,
           OutImmSrc0, OutImmSrc1, OutImmUse0, OutImmUse1, Count
  );

  modport slave (
    input  Flush, InVld, InInstr0, InInstr1, InPC0, InPC1, OutTake,
    output InReady, OutVld, OutInstr0, OutInstr1, OutPC0, OutPC1,
           OutImmSrc0, OutImmSrc1, OutImmUse0, OutImmUse1, Count
  );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - two-wide in-order instruction queue with opcode predecode
// Purpose: circular buffer between fetch and decode; accepts up to two
// instructions per cycle, predecodes the immediate format at enqueue and
// presents the two oldest entries to decode.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   q     : inst_queue_if.slave (enqueue, dequeue and status signals)
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  inst_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc_d    [DEPTH];
  logic [1:0]    src_q   [DEPTH];
  logic [1:0]    src_d   [DEPTH];
  logic          use_q   [DEPTH];
  logic          use_d   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [CW-1:0] count_q, count_d;

  logic          in_ready;
  logic [1:0]    out_vld;
  logic [1:0]    enq_cnt;
  logic [1:0]    deq_mask;
  logic [1:0]    deq_cnt;
  logic [2:0]    pd0, pd1;

  // Returns {imm_use, imm_src[1:0]} for a RISC-V major opcode.
  function automatic logic [2:0] predecode(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: predecode = 3'b100;
      7'b0100011:                         predecode = 3'b101;
      7'b1100011:                         predecode = 3'b110;
      7'b0110111, 7'b0010111:             predecode = 3'b111;
      default:                            predecode = 3'b000;
    endcase
  endfunction

  // Readiness and validity come from registered Count only.
  assign in_ready  = (count_q <= CW'(DEPTH - 2));
  assign out_vld   = {count_q >= CW'(2), count_q >= CW'(1)};
  assign wr_ptr_p1 = wr_ptr_q + PW'(1);
  assign rd_ptr_p1 = rd_ptr_q + PW'(1);
  assign pd0       = predecode(q.InInstr0[6:0]);
  assign pd1       = predecode(q.InInstr1[6:0]);

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    src_d    = src_q;
    use_d    = use_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    enq_cnt  = 2'd0;

    // InVld=10 is illegal and falls through to no write.
    if (in_ready && !q.Flush) begin
      case (q.InVld)
        2'b01:   enq_cnt = 2'd1;
        2'b11:   enq_cnt = 2'd2;
        default: enq_cnt = 2'd0;
      endcase
    end

    // Slot 1 may only leave together with slot 0 to keep program order.
    deq_mask = q.OutTake & out_vld;
    if (!deq_mask[0]) deq_mask[1] = 1'b0;
    deq_cnt = {1'b0, deq_mask[0]} + {1'b0, deq_mask[1]};

    if (enq_cnt != 2'd0) begin
      instr_d[wr_ptr_q] = q.InInstr0;
      pc_d[wr_ptr_q]    = q.InPC0;
      src_d[wr_ptr_q]   = pd0[1:0];
      use_d[wr_ptr_q]   = pd0[2];
    end
    if (enq_cnt == 2'd2) begin
      instr_d[wr_ptr_p1] = q.InInstr1;
      pc_d[wr_ptr_p1]    = q.InPC1;
      src_d[wr_ptr_p1]   = pd1[1:0];
      use_d[wr_ptr_p1]   = pd1[2];
    end

    wr_ptr_d = wr_ptr_q + PW'(enq_cnt);
    rd_ptr_d = rd_ptr_q + PW'(deq_cnt);
    count_d  = count_q + CW'(enq_cnt) - CW'(deq_cnt);

    // Flush overrides any same-cycle enqueue or dequeue.
    if (q.Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        src_q[i]   <= '0;
        use_q[i]   <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      src_q    <= src_d;
      use_q    <= use_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign q.InReady    = in_ready;
  assign q.OutVld     = out_vld;
  assign q.Count      = count_q;
  assign q.OutInstr0  = out_vld[0] ? instr_q[rd_ptr_q]  : '0;
  assign q.OutPC0     = out_vld[0] ? pc_q[rd_ptr_q]     : '0;
  assign q.OutImmSrc0 = out_vld[0] ? src_q[rd_ptr_q]    : '0;
  assign q.OutImmUse0 = out_vld[0] ? use_q[rd_ptr_q]    : 1'b0;
  assign q.OutInstr1  = out_vld[1] ? instr_q[rd_ptr_p1] : '0;
  assign q.OutPC1     = out_vld[1] ? pc_q[rd_ptr_p1]    : '0;
  assign q.OutImmSrc1 = out_vld[1] ? src_q[rd_ptr_p1]   : '0;
  assign q.OutImmUse1 = out_vld[1] ? use_q[rd_ptr_p1]   : 1'b0;
endmodule

// File: doc/inst_queue.md
# inst_queue

Two-wide instruction queue between fetch and decode in the superscalar core. Accepts up to two fetched instructions per cycle, stores them in program order with their PCs, and predecodes each opcode into the 2-bit immediate-format select consumed by the downstream immediate extender. It presents the two oldest entries to decode, which retires zero, one or two per cycle. Flush discards all contents on a redirect.

## Interface
- DEPTH, 4: entry count; power of two, ≥4.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Flush  in  1  discard all entries.
- InVld  in  2  enqueue valid per slot; slot 0 is older.
- InInstr0, InInstr1  in  32  fetched instructions.
- InPC0, InPC1  in  32  PCs of the fetched instructions.
- InReady  out  1  at least 2 entries free.
- OutVld  out  2  head entries valid; bit 0 is the oldest.
- OutInstr0, OutInstr1  out  32  head instructions.
- OutPC0, OutPC1  out  32  head PCs.
- OutImmSrc0, OutImmSrc1  out  2  immediate-format select.
- OutImmUse0, OutImmUse1  out  1  instruction carries an extender-format immediate.
- OutTake  in  2  decode consumes head entries.
- Count  out  log2(DEPTH)+1  occupied entries.

## Operation
- Circular buffer with write pointer, read pointer and Count register. Pointers wrap modulo DEPTH.
- Predecode at enqueue, from opcode bits [6:0]. The result is stored in the entry.
  - 0000011, 0010011, 1100111 give ImmSrc 00, ImmUse 1.
  - 0100011 gives ImmSrc 01, ImmUse 1.
  - 1100011 gives ImmSrc 10, ImmUse 1.
  - 0110111, 0010111 (U-type) give ImmSrc 11, ImmUse 1.
  - All others (R-type, JAL, SYSTEM, illegal) give ImmSrc 00, ImmUse 0.
- Enqueue occurs only when InReady=1 and Flush=0.
  - InVld=01 writes slot 0.
  - InVld=11 writes slot 0 then slot 1 at consecutive positions.
  - InVld=10 is illegal. It is ignored: no write.
- Dequeue mask = OutTake & OutVld. Bit 1 is additionally cleared if bit 0 is 0. Read pointer advances by the popcount of the mask.
- Count_next = Count + enq − deq. Simultaneous enqueue and dequeue are allowed in any combination.
- Flush clears Count to 0 and resets both pointers to 0. It wins over same-cycle enqueue and dequeue.
- Output slot 0 is the entry at the read pointer; slot 1 is the entry at read pointer + 1 (mod DEPTH).
  - OutVld[0] = Count≥1.
  - OutVld[1] = Count≥2.
- All Out* data fields are forced to 0 when the corresponding OutVld bit is 0.

## Timing
- Reset (async assert, sync-safe deassert): pointers 0, Count 0, OutVld 00, InReady 1, all Out* data 0.
- InReady = (DEPTH − Count) ≥ 2, from registered Count only. There is no combinational path from OutTake or InVld.
- Enqueue latency is 1 cycle. An entry written at edge N appears on outputs after edge N. There is no empty-queue bypass.
- Dequeue takes effect at the edge. The next entries appear the following cycle.
- Full (Count=DEPTH) or Count=DEPTH−1: InReady=0. Any InVld is dropped even if the same cycle dequeues.
- Empty: OutTake is ignored and Count stays 0.
- Flush with valid InVld: nothing is written, and Count=0 next cycle.
- Reset mid-operation: all state returns to reset values immediately. Entries are lost.

## Test plan
- Reset, then InVld=11 with 0x00500093 / 0x0020A423 and PCs 0x100 / 0x104, OutTake=00.
  - Next cycle: OutVld=11, OutImmSrc0=00, OutImmSrc1=01, both ImmUse=1, Count=2.
- Enqueue 0x00208863, 0x123452B7, 0x002081B3 over two cycles, draining with OutTake=01.
  - Results in order: ImmSrc 10/Use 1, ImmSrc 11/Use 1, ImmSrc 00/Use 0.
  - PCs and order are preserved.
- Fill DEPTH=4 with 4 entries.
  - InReady=0, Count=4.
  - InVld=11 with OutTake=11 in the same cycle: nothing enqueued, Count=2.
  - Next cycle InReady=1.
- Run 20 cycles of continuous InVld=11 and OutTake=11.
  - Pointer wrap produces no loss or duplication.
  - The PC sequence 0x0, 0x4, 0x8, … is observed strictly in order.
- Count=3 with Flush=1, InVld=11, OutTake=01.
  - Next cycle: Count=0, OutVld=00, all Out* data 0, InReady=1.
- OutTake=10 with Count=2 gives no dequeue. InVld=10 gives no write. Assert rst_n=0 mid-traffic: OutVld=00 immediately, before the next clock edge.
